fm_param_loader: RTL and testbench

Byte-serial command decoder and parameter writer for the FM operator engine. It accepts framed bytes from the MCU-facing SPI/bus slave and assembles 64-bit operator records. For each completed record it issues a one-cycle parameter write strobe (op address plus broken-out fields) into the FM generator's parameter memory. It also updates the 16-voice gate (keydown) register. It sits between the host interface and the FM generator's `pwaddr`/`pwe`/field/`gate` inputs.

---
 rtl/fm_param_loader.sv | 150 +++++++++++++++
 tb/tb_fm_param_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_param_loader.sv
// Byte-serial command decoder for the FM operator engine: assembles 64-bit operator records
// into a one-cycle parameter write, and loads the 16-voice gate register.
module fm_param_loader #(
   parameter int unsigned Osz = 7,
   parameter int unsigned Dsz = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             sel_i,
   input  logic [7:0]       din_i,
   input  logic             din_vld_i,
   output logic [Osz-1:0]   pwaddr_o,
   output logic [18:0]      frq_o,
   output logic [2:0]       wv_o,
   output logic [8:0]       adj_o,
   output logic [5:0]       ar_o,
   output logic [5:0]       dr_o,
   output logic [4:0]       sl_o,
   output logic [5:0]       rr_o,
   output logic             li_o,
   output logic             ri_o,
   output logic             mod_en_o,
   output logic             acc_en_o,
   output logic             acc_cl_o,
   output logic             fb_en_o,
   output logic             pwe_o,
   output logic [15:0]      gate_o,
   output logic             frm_err_o
);

   // Record width minus the unused top nibble, which simply shifts out of the register.
   localparam int unsigned RecW = Dsz * 8 - 4;

   typedef enum logic [2:0] {StIdle, StPar, StCommit, StGate, StDisc} state_e;

   state_e             state_q, state_d;
   logic [2:0]         cnt_q, cnt_d;
   logic [RecW-1:0]    sh_q, sh_d;
   logic [Osz-1:0]     addr_pend_q, addr_pend_d;
   logic               err_q, err_d;
   logic               gate_ld_q, gate_ld_d;
   logic [RecW-1:0]    rec_q;
   logic [Osz-1:0]     pwaddr_q;
   logic [15:0]        gate_q;
   logic               pwe_q;
   logic               acc;

   assign acc = sel_i & din_vld_i;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      addr_pend_d = addr_pend_q;
      err_d       = err_q;
      gate_ld_d   = 1'b0;
      unique case (state_q)
         // COMMIT also decodes a command so back-to-back frames run at 1 byte/clk.
         StIdle, StCommit: begin
            state_d = StIdle;
            if (acc) begin
               cnt_d = 3'd0;
               if (din_i[7]) begin
                  state_d     = StPar;
                  addr_pend_d = din_i[Osz-1:0];
               end else if (din_i == 8'h00) begin
                  state_d = StGate;
               end else begin
                  state_d = StDisc;
                  err_d   = 1'b1;
               end
            end
         end
         StPar: begin
            if (!sel_i) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else if (acc) begin
               sh_d  = {sh_q[RecW-9:0], din_i};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'(Dsz - 1)) state_d = StCommit;
            end
         end
         StGate: begin
            if (!sel_i) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else if (acc) begin
               sh_d  = {sh_q[RecW-9:0], din_i};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d   = StIdle;
                  gate_ld_d = 1'b1;
               end
            end
         end
         StDisc: begin
            if (!sel_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         sh_q        <= '0;
         addr_pend_q <= '0;
         err_q       <= 1'b0;
         gate_ld_q   <= 1'b0;
         rec_q       <= '0;
         pwaddr_q    <= '0;
         gate_q      <= '0;
         pwe_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         addr_pend_q <= addr_pend_d;
         err_q       <= err_d;
         gate_ld_q   <= gate_ld_d;
         pwe_q       <= (state_q == StCommit);
         if (state_q == StCommit) begin
            rec_q    <= sh_q;
            pwaddr_q <= addr_pend_q;
         end
         if (gate_ld_q) gate_q <= sh_q[15:0];
      end
   end

   assign pwaddr_o  = pwaddr_q;
   assign fb_en_o   = rec_q[59];
   assign acc_cl_o  = rec_q[58];
   assign acc_en_o  = rec_q[57];
   assign mod_en_o  = rec_q[56];
   assign ri_o      = rec_q[55];
   assign li_o      = rec_q[54];
   assign rr_o      = rec_q[53:48];
   assign sl_o      = rec_q[47:43];
   assign dr_o      = rec_q[42:37];
   assign ar_o      = rec_q[36:31];
   assign adj_o     = rec_q[30:22];
   assign wv_o      = rec_q[21:19];
   assign frq_o     = rec_q[18:0];
   assign pwe_o     = pwe_q;
   assign gate_o    = gate_q;
   assign frm_err_o = err_q;

endmodule

// File: tb/tb_fm_param_loader.sv
// Directed plus randomized frames against a frame-level model of the loader.
module tb_fm_param_loader;

   logic        clk = 1'b0;
   logic        rst_n, sel, din_vld;
   logic [7:0]  din;
   logic [6:0]  pwaddr;
   logic [18:0] frq;
   logic [2:0]  wv;
   logic [8:0]  adj;
   logic [5:0]  ar, dr, rr;
   logic [4:0]  sl;
   logic        li, ri, mod_en, acc_en, acc_cl, fb_en, pwe, frm_err;
   logic [15:0] gate;

   fm_param_loader #(.Osz(7), .Dsz(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .sel_i(sel), .din_i(din), .din_vld_i(din_vld),
      .pwaddr_o(pwaddr), .frq_o(frq), .wv_o(wv), .adj_o(adj), .ar_o(ar), .dr_o(dr),
      .sl_o(sl), .rr_o(rr), .li_o(li), .ri_o(ri), .mod_en_o(mod_en), .acc_en_o(acc_en),
      .acc_cl_o(acc_cl), .fb_en_o(fb_en), .pwe_o(pwe), .gate_o(gate), .frm_err_o(frm_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int pwe_cnt = 0;
   int pwe_cyc[$];
   logic [6:0] pwe_addr[$];

   // Frame-level model: last committed record/address, gate value, sticky error.
   logic [6:0]  m_addr = '0;
   logic [63:0] m_rec = '0;
   logic [15:0] m_gate = '0;
   logic        m_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (pwe === 1'b1) begin
         pwe_cnt++;
         pwe_cyc.push_back(cyc);
         pwe_addr.push_back(pwaddr);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, ".pwaddr"}, 64'(pwaddr), 64'(m_addr));
      chk({tag, ".fields"}, 64'({fb_en, acc_cl, acc_en, mod_en, ri, li, rr, sl, dr, ar, adj,
                                wv, frq}), 64'(m_rec[59:0]));
      chk({tag, ".gate"}, 64'(gate), 64'(m_gate));
      chk({tag, ".frm_err"}, 64'(frm_err), 64'(m_err));
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic put(input logic [7:0] b);
      sel = 1'b1;
      din = b;
      din_vld = 1'b1;
      cycle();
      din_vld = 1'b0;
   endtask

   // sel low with junk strobes that must be ignored
   task automatic idle(input int n);
      sel = 1'b0;
      repeat (n) begin
         din = 8'($urandom);
         din_vld = 1'($urandom);
         cycle();
      end
      din_vld = 1'b0;
   endtask

   task automatic par_frame(input logic [6:0] op, input logic [63:0] rec);
      int c0;
      c0 = pwe_cnt;
      put({1'b1, op});
      for (int i = 7; i >= 0; i--) put(rec[i*8 +: 8]);
      chk("par.pwe_early", 64'(pwe), 64'd0);
      chk_state("par.hold");
      cycle();
      m_addr = op;
      m_rec = rec;
      chk("par.pwe", 64'(pwe), 64'd1);
      chk_state("par.commit");
      cycle();
      chk("par.pwe_off", 64'(pwe), 64'd0);
      chk("par.npulse", 64'(pwe_cnt - c0), 64'd1);
   endtask

   task automatic gate_frame(input logic [7:0] hi, input logic [7:0] lo);
      int c0;
      c0 = pwe_cnt;
      put(8'h00);
      put(hi);
      chk("gate.b1", 64'(gate), 64'(m_gate));
      put(lo);
      chk("gate.b2", 64'(gate), 64'(m_gate));
      cycle();
      m_gate = {hi, lo};
      chk("gate.load", 64'(gate), 64'(m_gate));
      chk("gate.nopwe", 64'(pwe_cnt - c0), 64'd0);
   endtask

   task automatic abort_frame(input logic is_par, input int k);
      int c0;
      c0 = pwe_cnt;
      put(is_par ? {1'b1, 7'($urandom)} : 8'h00);
      for (int i = 0; i < k; i++) put(8'($urandom));
      sel = 1'b0;
      cycle();
      cycle();
      m_err = 1'b1;
      chk_state("abort");
      chk("abort.nopwe", 64'(pwe_cnt - c0), 64'd0);
   endtask

   initial begin
      int c0, n;
      logic [63:0] ra, rb;
      sel = 1'b0;
      din = 8'h00;
      din_vld = 1'b0;
      rst_n = 1'b0;
      #12;
      chk_state("reset");
      chk("reset.pwe", 64'(pwe), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // All-ones record to op 5; top nibble must be dropped
      par_frame(7'd5, 64'h0FFF_FFFF_FFFF_FFFF);
      chk("t1.frq", 64'(frq), 64'h7FFFF);
      chk("t1.fb_en", 64'(fb_en), 64'd1);
      idle(2);

      gate_frame(8'h12, 8'h34);
      idle(1);

      // Unknown command discards the rest of the frame, including a valid-looking param frame
      c0 = pwe_cnt;
      put(8'h10);
      put(8'h85);
      for (int i = 0; i < 8; i++) put(8'hFF);
      cycle();
      cycle();
      m_err = 1'b1;
      chk_state("disc");
      chk("disc.nopwe", 64'(pwe_cnt - c0), 64'd0);
      idle(1);
      par_frame(7'h22, {$urandom, $urandom});

      @(negedge clk);
      rst_n = 1'b0;
      m_addr = '0;
      m_rec = '0;
      m_gate = '0;
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      par_frame(7'h11, {$urandom, $urandom});
      idle(1);
      sel = 1'b1;
      put(8'h81);
      for (int i = 0; i < 4; i++) put(8'($urandom));
      sel = 1'b0;
      cycle();
      m_err = 1'b1;
      chk_state("t3.abort");
      idle(1);
      par_frame(7'h7F, {$urandom, $urandom});
      idle(1);

      // Two param frames back-to-back under one sel
      c0 = pwe_cnt;
      n = pwe_cyc.size();
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      put(8'h83);
      for (int i = 7; i >= 0; i--) put(ra[i*8 +: 8]);
      put(8'h84);
      for (int i = 7; i >= 0; i--) put(rb[i*8 +: 8]);
      cycle();
      cycle();
      chk("b2b.npulse", 64'(pwe_cnt - c0), 64'd2);
      if (pwe_cyc.size() >= n + 2) begin
         chk("b2b.gap", 64'(pwe_cyc[n+1] - pwe_cyc[n]), 64'd9);
         chk("b2b.addr0", 64'(pwe_addr[n]), 64'd3);
         chk("b2b.addr1", 64'(pwe_addr[n+1]), 64'd4);
      end
      m_addr = 7'd4;
      m_rec = rb;
      chk_state("b2b");
      idle(1);

      // Reset between data bytes 3 and 4 takes effect without a clock edge
      gate_frame(8'($urandom), 8'($urandom));
      idle(1);
      put(8'h8A);
      for (int i = 0; i < 3; i++) put(8'($urandom));
      rst_n = 1'b0;
      #1;
      m_addr = '0;
      m_rec = '0;
      m_gate = '0;
      m_err = 1'b0;
      chk_state("rstmid");
      chk("rstmid.pwe", 64'(pwe), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);
      par_frame(7'h2A, {$urandom, $urandom});
      idle(1);

      for (int it = 0; it < 30; it++) begin
         case ($urandom_range(0, 3))
            0: par_frame(7'($urandom), {$urandom, $urandom});
            1: gate_frame(8'($urandom), 8'($urandom));
            2: abort_frame(1'b1, int'($urandom_range(0, 7)));
            default: abort_frame(1'b0, int'($urandom_range(0, 1)));
         endcase
         idle(int'($urandom_range(1, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
